dcpu_bus_arbiter: RTL and testbench
===================================

DCPU_BUS_ARBITER -- requirements
Module: dcpu_bus_arbiter

Interface
REQ-001 Parameter W, default 16, bus data/address width.
REQ-002 Parameter TMO, default 255, ack-timeout limit in cycles (1..65535).
REQ-003 i_clk  input  1  clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_m0_addr, i_m0_dat  input  W  master 0 (CPU) address, write data.
REQ-006 i_m0_we, i_m0_cs  input  1  master 0 write enable, request (held until ack).
REQ-007 o_m0_dat  output  W; o_m0_ack, o_m0_err  output  1  master 0 read data, completion, timeout flag.
REQ-008 i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs, o_m1_dat, o_m1_ack, o_m1_err  same widths and meanings for master 1 (loader/DMA).
REQ-009 o_s_addr, o_s_dat  output  W; o_s_we, o_s_cs  output  1  shared slave bus.
REQ-010 i_s_dat  input  W; i_s_ack  input  1  slave read data, completion.
REQ-011 o_grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 0 when idle.

Function
REQ-012 FSM states: IDLE, BUSY.
REQ-013 IDLE: if any i_mX_cs, latch the winner into the grant register and enter BUSY next cycle; otherwise stay IDLE.
REQ-014 Arbitration is round-robin: on simultaneous requests, the master not granted last wins; with a single requester, that requester wins.
REQ-015 Grant latency: 1 cycle from request in IDLE to o_s_cs high.
REQ-016 BUSY: o_s_addr, o_s_dat, o_s_we equal the granted master's inputs combinationally; o_s_cs = 1.
REQ-017 IDLE: o_s_cs = 0, o_s_we = 0, o_s_addr = 0, o_s_dat = 0.
REQ-018 BUSY with i_s_ack = 1: the granted master's o_mX_ack = 1 and o_mX_dat = i_s_dat in the same cycle; the FSM returns to IDLE; the last-grant register is updated.
REQ-019 The non-granted master always sees ack = 0, err = 0, dat = 0.
REQ-020 The timeout counter clears on entry to BUSY and increments each BUSY cycle without i_s_ack.
REQ-021 When the counter reaches TMO without ack: the granted master's o_mX_ack = 1 and o_mX_err = 1 for one cycle, o_mX_dat = 0, and the FSM returns to IDLE.
REQ-022 An ack arriving in the same cycle as timeout takes precedence (err = 0).
REQ-023 If the granted master drops cs while in BUSY: abort with no ack pulse, o_s_cs = 0 that cycle, and return to IDLE.
REQ-024 Back-to-back: at least one IDLE cycle between transactions; re-arbitration occurs in that cycle.
REQ-025 The grant never changes while in BUSY.

Reset
REQ-026 On i_reset: state = IDLE, grant = 0, timeout counter = 0, and last-grant = m1, so m0 wins the first tie.
REQ-027 Reset asserted mid-BUSY aborts the transaction: no ack or err is issued, and o_s_cs = 0 in the cycle after the reset edge.
REQ-028 All outputs are 0 while in reset.

Structure
REQ-029 A shared package dcpu_pkg holds the FSM state encoding, the default W, and the default TMO.
REQ-030 One sub-module, dcpu_rr_arbiter2 (2-way round-robin pick from request bits and last-grant), is instantiated once.
REQ-031 All outputs other than o_s_*, o_mX_ack, o_mX_dat, and o_mX_err are driven from registers.

Verification
REQ-032 m0 reads addr 0x0010; slave acks with 0xBEEF on the 2nd BUSY cycle -> o_s_cs high 1 cycle after request, o_m0_ack = 1 and o_m0_dat = 0xBEEF in the ack cycle.
REQ-033 m0 and m1 request together from reset -> m0 is served first, m1 next after one IDLE cycle; with both held, grants alternate m0, m1, m0.
REQ-034 m1 writes 0x1234 to 0x8000 with no slave ack, TMO = 4 -> o_m1_ack = 1 and o_m1_err = 1 four cycles after BUSY entry; FSM returns to IDLE.
REQ-035 Ack arrives exactly on the timeout cycle -> ack with err = 0, and data is passed through.
REQ-036 i_reset pulsed during m1 BUSY -> no ack or err to m1; o_grant = 0; a subsequent simultaneous request grants m0.
REQ-037 Granted m0 drops cs in BUSY -> no ack, return to IDLE, pending m1 is granted next cycle.

Source files
------------

// File: rtl/dcpu_pkg.sv
// Shared definitions for the DCPU bus arbiter slice.
// State encoding, one-hot grant codes and parameter defaults.
package dcpu_pkg;

    localparam int unsigned DefaultW   = 16;
    localparam int unsigned DefaultTmo = 255;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantM0   = 2'b01;
    localparam logic [1:0] GrantM1   = 2'b10;

endpackage

// File: rtl/dcpu_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the master not granted last wins.
// A single requester always wins; no request yields no grant.
module dcpu_rr_arbiter2
    import dcpu_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        unique case (i_req)
            2'b11:   o_grant = i_last[0] ? GrantM1 : GrantM0;
            default: o_grant = i_req;
        endcase
    end

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// Two-master to one-slave bus arbiter with round-robin grant and ack timeout.
// One transaction at a time; the bus always drops to IDLE between transactions.
module dcpu_bus_arbiter
    import dcpu_pkg::*;
#(
    parameter int unsigned W   = DefaultW,
    parameter int unsigned TMO = DefaultTmo
) (
    input  logic         i_clk,
    input  logic         i_reset,

    input  logic [W-1:0] i_m0_addr,
    input  logic [W-1:0] i_m0_dat,
    input  logic         i_m0_we,
    input  logic         i_m0_cs,
    output logic [W-1:0] o_m0_dat,
    output logic         o_m0_ack,
    output logic         o_m0_err,

    input  logic [W-1:0] i_m1_addr,
    input  logic [W-1:0] i_m1_dat,
    input  logic         i_m1_we,
    input  logic         i_m1_cs,
    output logic [W-1:0] o_m1_dat,
    output logic         o_m1_ack,
    output logic         o_m1_err,

    output logic [W-1:0] o_s_addr,
    output logic [W-1:0] o_s_dat,
    output logic         o_s_we,
    output logic         o_s_cs,
    input  logic [W-1:0] i_s_dat,
    input  logic         i_s_ack,

    output logic [1:0]   o_grant
);

    localparam logic [15:0] TmoCnt = 16'(TMO);

    logic [0:0]   state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic [1:0]   last_q, last_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [1:0]   pick;

    logic         sel_cs;
    logic         sel_we;
    logic [W-1:0] sel_addr;
    logic [W-1:0] sel_dat;

    logic         s_cs;
    logic         done_ack;
    logic         done_err;
    logic         busy;
    logic         ack_v;
    logic         err_v;

    dcpu_rr_arbiter2 u_rr (
        .i_req   ({i_m1_cs, i_m0_cs}),
        .i_last  (last_q),
        .o_grant (pick)
    );

    // The grant register is stable through BUSY, so it alone steers the slave bus.
    always_comb begin
        sel_cs   = grant_q[1] ? i_m1_cs   : i_m0_cs;
        sel_we   = grant_q[1] ? i_m1_we   : i_m0_we;
        sel_addr = grant_q[1] ? i_m1_addr : i_m0_addr;
        sel_dat  = grant_q[1] ? i_m1_dat  : i_m0_dat;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        s_cs     = 1'b0;
        done_ack = 1'b0;
        done_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick != GrantNone) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!sel_cs) begin
                    // Master withdrew: end silently, slave never sees this cycle.
                    grant_d = GrantNone;
                    last_d  = grant_q;
                    state_d = StIdle;
                end else begin
                    s_cs = 1'b1;
                    if (i_s_ack) begin
                        done_ack = 1'b1;
                        grant_d  = GrantNone;
                        last_d   = grant_q;
                        state_d  = StIdle;
                    end else if (cnt_q == TmoCnt) begin
                        done_ack = 1'b1;
                        done_err = 1'b1;
                        grant_d  = GrantNone;
                        last_d   = grant_q;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            grant_q <= GrantNone;
            last_q  <= GrantM1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign busy  = (state_q == StBusy) && !i_reset;
    assign ack_v = done_ack && !i_reset;
    assign err_v = done_err && !i_reset;

    assign o_s_cs   = s_cs && !i_reset;
    assign o_s_we   = busy && sel_we;
    assign o_s_addr = busy ? sel_addr : '0;
    assign o_s_dat  = busy ? sel_dat  : '0;

    assign o_m0_ack = ack_v && grant_q[0];
    assign o_m0_err = err_v && grant_q[0];
    assign o_m0_dat = (ack_v && !err_v && grant_q[0]) ? i_s_dat : '0;

    assign o_m1_ack = ack_v && grant_q[1];
    assign o_m1_err = err_v && grant_q[1];
    assign o_m1_dat = (ack_v && !err_v && grant_q[1]) ? i_s_dat : '0;

    assign o_grant = grant_q;

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Self-checking bench for dcpu_bus_arbiter (TMO = 4) using a completion scoreboard.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dcpu_bus_arbiter;

    localparam int unsigned W   = 16;
    localparam int unsigned TMO = 4;

    typedef struct packed {
        logic [1:0]   who;
        logic [W-1:0] dat;
        logic         err;
    } sb_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] m0_addr, m0_dat, m1_addr, m1_dat, s_dat;
    logic         m0_we, m0_cs, m1_we, m1_cs, s_ack;
    logic [W-1:0] o_m0_dat, o_m1_dat, o_s_addr, o_s_dat;
    logic         o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_s_we, o_s_cs;
    logic [1:0]   o_grant;

    sb_t sb[$];
    int  errors = 0;
    int  checks = 0;

    dcpu_bus_arbiter #(
        .W   (W),
        .TMO (TMO)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_m0_addr (m0_addr),
        .i_m0_dat  (m0_dat),
        .i_m0_we   (m0_we),
        .i_m0_cs   (m0_cs),
        .o_m0_dat  (o_m0_dat),
        .o_m0_ack  (o_m0_ack),
        .o_m0_err  (o_m0_err),
        .i_m1_addr (m1_addr),
        .i_m1_dat  (m1_dat),
        .i_m1_we   (m1_we),
        .i_m1_cs   (m1_cs),
        .o_m1_dat  (o_m1_dat),
        .o_m1_ack  (o_m1_ack),
        .o_m1_err  (o_m1_err),
        .o_s_addr  (o_s_addr),
        .o_s_dat   (o_s_dat),
        .o_s_we    (o_s_we),
        .o_s_cs    (o_s_cs),
        .i_s_dat   (s_dat),
        .i_s_ack   (s_ack),
        .o_grant   (o_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic sample_ack(output sb_t got);
        got.who = {o_m1_ack, o_m0_ack};
        got.dat = o_m1_ack ? o_m1_dat : o_m0_dat;
        got.err = o_m1_ack ? o_m1_err : o_m0_err;
    endtask

    task automatic wait_ack(input int bound, output int cycles, output logic seen);
        seen = 1'b0;
        cycles = 0;
        for (int c = 0; c <= bound; c++) begin
            cycles = c;
            if (o_m0_ack || o_m1_ack) begin
                seen = 1'b1;
                break;
            end
            if (c < bound) begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; m0_cs = 1'b1; m0_addr = 16'h00AA;
        @(negedge clk);
        #1;
        checks++;
        if (o_s_cs !== 1'b0 || o_s_addr !== 16'h0 || o_m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: cs=%b addr=%h ack=%b, want 0 0 0", o_s_cs, o_s_addr, o_m0_ack);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant: got %b want 00", o_grant);
        end
        rst = 1'b0; m0_cs = 1'b0;
        #1;
        checks++;
        if (o_s_cs !== 1'b0 || o_grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: cs=%b grant=%b want 0 00", o_s_cs, o_grant);
        end
    endtask

    task automatic test_m0_read();
        sb_t got, want;
        @(negedge clk);
        m0_addr = 16'h0010; m0_we = 1'b0; m0_cs = 1'b1;
        sb.push_back('{who: 2'b01, dat: 16'hBEEF, err: 1'b0});
        #1;
        checks++;
        if (o_s_cs !== 1'b0) begin
            errors++;
            $display("FAIL read_latency: cs=%b in request cycle, want 0", o_s_cs);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_s_cs !== 1'b1 || o_s_addr !== 16'h0010 || o_grant !== 2'b01 || o_m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL read_busy1: cs=%b addr=%h grant=%b ack=%b want 1 0010 01 0",
                     o_s_cs, o_s_addr, o_grant, o_m0_ack);
        end
        @(negedge clk);
        s_ack = 1'b1; s_dat = 16'hBEEF;
        #1;
        sample_ack(got);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL read_sb: ack seen with empty scoreboard");
        end else begin
            want = sb.pop_front();
            checks++;
            if (got.who !== want.who) begin
                errors++;
                $display("FAIL read_who: got %b want %b", got.who, want.who);
            end
            checks++;
            if (got.dat !== want.dat || got.err !== want.err) begin
                errors++;
                $display("FAIL read_dat: got %h/%b want %h/%b", got.dat, got.err, want.dat, want.err);
            end
        end
        checks++;
        if (o_m1_ack !== 1'b0 || o_m1_dat !== 16'h0 || o_m1_err !== 1'b0) begin
            errors++;
            $display("FAIL read_other: m1 ack=%b dat=%h err=%b want 0", o_m1_ack, o_m1_dat, o_m1_err);
        end
        @(negedge clk);
        s_ack = 1'b0; m0_cs = 1'b0;
        #1;
        checks++;
        if (o_s_cs !== 1'b0 || o_grant !== 2'b00) begin
            errors++;
            $display("FAIL read_idle: cs=%b grant=%b want 0 00", o_s_cs, o_grant);
        end
    endtask

    task automatic test_round_robin();
        sb_t got, want;
        logic [1:0] exp_who [3];
        exp_who[0] = 2'b01; exp_who[1] = 2'b10; exp_who[2] = 2'b01;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m0_addr = 16'h0100; m0_we = 1'b1; m0_dat = 16'h1111; m0_cs = 1'b1;
        m1_addr = 16'h0200; m1_we = 1'b0; m1_cs = 1'b1;
        for (int k = 0; k < 3; k++)
            sb.push_back('{who: exp_who[k], dat: 16'hD000 + 16'(k), err: 1'b0});
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (o_grant !== exp_who[k]) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b want %b", k, o_grant, exp_who[k]);
            end
            checks++;
            if (o_s_addr !== (exp_who[k] == 2'b10 ? 16'h0200 : 16'h0100)) begin
                errors++;
                $display("FAIL rr_addr%0d: got %h", k, o_s_addr);
            end
            s_ack = 1'b1; s_dat = 16'hD000 + 16'(k);
            #1;
            sample_ack(got);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rr_sb%0d: ack seen with empty scoreboard", k);
            end else begin
                want = sb.pop_front();
                checks++;
                if (got.who !== want.who || got.dat !== want.dat || got.err !== want.err) begin
                    errors++;
                    $display("FAIL rr_ack%0d: got %b/%h/%b want %b/%h/%b", k,
                             got.who, got.dat, got.err, want.who, want.dat, want.err);
                end
            end
            @(negedge clk);
            s_ack = 1'b0;
            #1;
            checks++;
            if (o_s_cs !== 1'b0 || o_grant !== 2'b00) begin
                errors++;
                $display("FAIL rr_gap%0d: cs=%b grant=%b want 0 00", k, o_s_cs, o_grant);
            end
        end
        m0_cs = 1'b0; m1_cs = 1'b0; m0_we = 1'b0;
    endtask

    task automatic test_timeout();
        sb_t got, want;
        int n;
        logic seen;
        @(negedge clk);
        m1_addr = 16'h8000; m1_dat = 16'h1234; m1_we = 1'b1; m1_cs = 1'b1;
        sb.push_back('{who: 2'b10, dat: 16'h0000, err: 1'b1});
        @(negedge clk);
        #1;
        checks++;
        if (o_s_addr !== 16'h8000 || o_s_dat !== 16'h1234 || o_s_we !== 1'b1 || o_grant !== 2'b10) begin
            errors++;
            $display("FAIL tmo_bus: addr=%h dat=%h we=%b grant=%b want 8000 1234 1 10",
                     o_s_addr, o_s_dat, o_s_we, o_grant);
        end
        wait_ack(10, n, seen);
        checks++;
        if (!seen || n != 4) begin
            errors++;
            $display("FAIL tmo_cycle: seen=%b at busy cycle %0d want 1 at 4", seen, n);
        end
        sample_ack(got);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL tmo_sb: scoreboard empty");
        end else begin
            want = sb.pop_front();
            checks++;
            if (got.who !== want.who || got.dat !== want.dat || got.err !== want.err) begin
                errors++;
                $display("FAIL tmo_ack: got %b/%h/%b want %b/%h/%b",
                         got.who, got.dat, got.err, want.who, want.dat, want.err);
            end
        end
        @(negedge clk);
        m1_cs = 1'b0; m1_we = 1'b0;
        #1;
        checks++;
        if (o_s_cs !== 1'b0 || o_grant !== 2'b00 || o_m1_ack !== 1'b0 || o_m1_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_idle: cs=%b grant=%b ack=%b err=%b want 0", o_s_cs, o_grant, o_m1_ack, o_m1_err);
        end
    endtask

    task automatic test_ack_on_timeout();
        sb_t got, want;
        @(negedge clk);
        m0_addr = 16'h0042; m0_we = 1'b0; m0_cs = 1'b1;
        sb.push_back('{who: 2'b01, dat: 16'hCAFE, err: 1'b0});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (o_m0_ack !== 1'b0 || o_s_cs !== 1'b1) begin
                errors++;
                $display("FAIL edge_early%0d: ack=%b cs=%b want 0 1", k, o_m0_ack, o_s_cs);
            end
        end
        @(negedge clk);
        s_ack = 1'b1; s_dat = 16'hCAFE;
        #1;
        sample_ack(got);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL edge_sb: scoreboard empty");
        end else begin
            want = sb.pop_front();
            checks++;
            if (got.who !== want.who || got.dat !== want.dat || got.err !== want.err) begin
                errors++;
                $display("FAIL edge_ack: got %b/%h/%b want %b/%h/%b",
                         got.who, got.dat, got.err, want.who, want.dat, want.err);
            end
        end
        @(negedge clk);
        s_ack = 1'b0; m0_cs = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_busy();
        sb_t got, want;
        @(negedge clk);
        m1_addr = 16'h3000; m1_we = 1'b0; m1_cs = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (o_grant !== 2'b10) begin
            errors++;
            $display("FAIL rstb_grant: got %b want 10", o_grant);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (o_s_cs !== 1'b0 || o_m1_ack !== 1'b0 || o_m1_err !== 1'b0) begin
            errors++;
            $display("FAIL rstb_held: cs=%b ack=%b err=%b want 0", o_s_cs, o_m1_ack, o_m1_err);
        end
        @(negedge clk);
        rst = 1'b0; m0_addr = 16'h0044; m0_cs = 1'b1;
        sb.push_back('{who: 2'b01, dat: 16'h5555, err: 1'b0});
        #1;
        checks++;
        if (o_grant !== 2'b00 || o_s_cs !== 1'b0 || o_m1_ack !== 1'b0 || o_m1_err !== 1'b0) begin
            errors++;
            $display("FAIL rstb_after: grant=%b cs=%b ack=%b err=%b want 00 0 0 0",
                     o_grant, o_s_cs, o_m1_ack, o_m1_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_grant !== 2'b01 || o_s_addr !== 16'h0044) begin
            errors++;
            $display("FAIL rstb_tie: grant=%b addr=%h want 01 0044", o_grant, o_s_addr);
        end
        s_ack = 1'b1; s_dat = 16'h5555;
        #1;
        sample_ack(got);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL rstb_sb: scoreboard empty");
        end else begin
            want = sb.pop_front();
            checks++;
            if (got.who !== want.who || got.dat !== want.dat || got.err !== want.err) begin
                errors++;
                $display("FAIL rstb_ack: got %b/%h/%b want %b/%h/%b",
                         got.who, got.dat, got.err, want.who, want.dat, want.err);
            end
        end
        @(negedge clk);
        s_ack = 1'b0; m0_cs = 1'b0; m1_cs = 1'b0;
        #1;
    endtask

    task automatic test_abort();
        sb_t got, want;
        @(negedge clk);
        m0_addr = 16'h0077; m0_cs = 1'b1;
        @(negedge clk);
        m1_addr = 16'h0900; m1_we = 1'b0; m1_cs = 1'b1;
        #1;
        checks++;
        if (o_grant !== 2'b01 || o_s_cs !== 1'b1) begin
            errors++;
            $display("FAIL abort_grant: grant=%b cs=%b want 01 1", o_grant, o_s_cs);
        end
        @(negedge clk);
        m0_cs = 1'b0;
        #1;
        checks++;
        if (o_s_cs !== 1'b0 || o_m0_ack !== 1'b0 || o_m0_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: cs=%b ack=%b err=%b want 0 0 0", o_s_cs, o_m0_ack, o_m0_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_grant !== 2'b00 || o_s_cs !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: grant=%b cs=%b want 00 0", o_grant, o_s_cs);
        end
        sb.push_back('{who: 2'b10, dat: 16'h0909, err: 1'b0});
        @(negedge clk);
        #1;
        checks++;
        if (o_grant !== 2'b10 || o_s_cs !== 1'b1 || o_s_addr !== 16'h0900) begin
            errors++;
            $display("FAIL abort_next: grant=%b cs=%b addr=%h want 10 1 0900", o_grant, o_s_cs, o_s_addr);
        end
        s_ack = 1'b1; s_dat = 16'h0909;
        #1;
        sample_ack(got);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL abort_sb: scoreboard empty");
        end else begin
            want = sb.pop_front();
            checks++;
            if (got.who !== want.who || got.dat !== want.dat || got.err !== want.err) begin
                errors++;
                $display("FAIL abort_ack: got %b/%h/%b want %b/%h/%b",
                         got.who, got.dat, got.err, want.who, want.dat, want.err);
            end
        end
        @(negedge clk);
        s_ack = 1'b0; m1_cs = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_addr = '0; m0_dat = '0; m0_we = 1'b0; m0_cs = 1'b0;
        m1_addr = '0; m1_dat = '0; m1_we = 1'b0; m1_cs = 1'b0;
        s_dat = '0; s_ack = 1'b0;

        test_reset();
        test_m0_read();
        test_round_robin();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid_busy();
        test_abort();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d completions never arrived, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
